// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with an internal ALU decoder and an optional memory-wait timeout.
// Define MIPS_MC_JLINK_EN to add the JAL and JR instructions.
module mips_multicycle_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 0,
    parameter int unsigned TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       signext,
    output logic       shiftl16,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       link,
    output logic       illegal,
    output logic       bus_err
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_MC_JLINK_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] F_JR     = 6'b001000;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [2:0]      alu_funct;
    logic            funct_ok;
    logic            mem_state;
    logic            timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // R-type funct to ALU operation
    always_comb begin
        alu_funct = ALU_AND;
        funct_ok  = 1'b1;
        case (funct)
            6'b100000, 6'b100001: alu_funct = ALU_ADD;
            6'b100010, 6'b100011: alu_funct = ALU_SUB;
            6'b100100:            alu_funct = ALU_AND;
            6'b100101:            alu_funct = ALU_OR;
            6'b101010, 6'b101011: alu_funct = ALU_SLT;
            default:              funct_ok  = 1'b0;
        endcase
    end

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout   = (BUS_TIMEOUT != 0) && mem_state && !mem_ready
                       && (cnt_q == TO_W'(BUS_TIMEOUT));

    // Counter restarts on every state change and after a timeout; saturates otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (timeout || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (mem_state && !mem_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = ALU_AND;
        signext    = 1'b0;
        shiftl16   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        link       = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: state_d = S_IEXEC;
                    OP_J:                             state_d = S_JUMP;
                    OP_RTYPE: begin
                        state_d = S_EXEC;
`ifdef MIPS_MC_JLINK_EN
                        if (funct == F_JR) state_d = S_JR;
`endif
                    end
`ifdef MIPS_MC_JLINK_EN
                    OP_JAL:                           state_d = S_JAL;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                signext    = 1'b1;
                alucontrol = ALU_ADD;
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            // A timed-out store drops its strobe in the abort cycle
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = !timeout;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                if (funct_ok) begin
                    alucontrol = alu_funct;
                    state_d    = S_ALUWB;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = (op == OP_BEQ) ? zero : !zero;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                shiftl16 = (op == OP_LUI);
                if (op == OP_ORI) begin
                    alucontrol = ALU_OR;
                end else begin
                    alucontrol = ALU_ADD;
                    signext    = 1'b1;
                end
                state_d = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MIPS_MC_JLINK_EN
            S_JAL: begin
                pcsrc    = 2'b10;
                pcen     = 1'b1;
                regwrite = 1'b1;
                link     = 1'b1;
                state_d  = S_FETCH;
            end
            S_JR: begin
                pcsrc   = 2'b11;
                pcen    = 1'b1;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
        // Reset masks every strobe and select in the cycles it is held
        if (reset) begin
            iord       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            pcen       = 1'b0;
            pcsrc      = 2'b00;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            alucontrol = 3'b000;
            signext    = 1'b0;
            shiftl16   = 1'b0;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            link       = 1'b0;
            illegal    = 1'b0;
            bus_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table vectors, corner sequences, and random
// instruction streams expanded into expected per-cycle output lists.
module tb_mips_multicycle_ctrl;
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       signext;
        logic       shiftl16;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       link;
        logic       illegal;
        logic       bus_err;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        outs_t      exp_dec;
        outs_t      exp_nxt;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ADDIU = 6'b001001;
    localparam logic [5:0] ORI = 6'b001101, LUI = 6'b001111, JMP = 6'b000010, JAL = 6'b000011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] cur_op = '0, cur_funct = '0;

    logic iord_a, irwrite_a, memwrite_a, pcen_a, alusrca_a, signext_a, shiftl16_a;
    logic regwrite_a, regdst_a, memtoreg_a, link_a, illegal_a, bus_err_a;
    logic [1:0] pcsrc_a, alusrcb_a;
    logic [2:0] alucontrol_a;
    logic iord_b, irwrite_b, memwrite_b, pcen_b, alusrca_b, signext_b, shiftl16_b;
    logic regwrite_b, regdst_b, memtoreg_b, link_b, illegal_b, bus_err_b;
    logic [1:0] pcsrc_b, alusrcb_b;
    logic [2:0] alucontrol_b;
    outs_t o_a, o_b;

    int n_vec = 0;
    int n_bad = 0;
    outs_t exp_q[$];
    bit    rdy_q[$];
    vec_t  tbl[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord_a), .irwrite(irwrite_a), .memwrite(memwrite_a), .pcen(pcen_a),
        .pcsrc(pcsrc_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a), .alucontrol(alucontrol_a),
        .signext(signext_a), .shiftl16(shiftl16_a), .regwrite(regwrite_a), .regdst(regdst_a),
        .memtoreg(memtoreg_a), .link(link_a), .illegal(illegal_a), .bus_err(bus_err_a)
    );

    mips_multicycle_ctrl #(.BUS_TIMEOUT(2), .TO_W(8)) dut_to (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord_b), .irwrite(irwrite_b), .memwrite(memwrite_b), .pcen(pcen_b),
        .pcsrc(pcsrc_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b), .alucontrol(alucontrol_b),
        .signext(signext_b), .shiftl16(shiftl16_b), .regwrite(regwrite_b), .regdst(regdst_b),
        .memtoreg(memtoreg_b), .link(link_b), .illegal(illegal_b), .bus_err(bus_err_b)
    );

    assign o_a = {iord_a, irwrite_a, memwrite_a, pcen_a, pcsrc_a, alusrca_a, alusrcb_a,
                  alucontrol_a, signext_a, shiftl16_a, regwrite_a, regdst_a, memtoreg_a,
                  link_a, illegal_a, bus_err_a};
    assign o_b = {iord_b, irwrite_b, memwrite_b, pcen_b, pcsrc_b, alusrca_b, alusrcb_b,
                  alucontrol_b, signext_b, shiftl16_b, regwrite_b, regdst_b, memtoreg_b,
                  link_b, illegal_b, bus_err_b};

    // Expected output vectors, one per datapath step
    function automatic bit op_known(logic [5:0] o);
        bit k;
        k = (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == BNE) || (o == ADDI)
            || (o == ADDIU) || (o == ORI) || (o == LUI) || (o == JMP);
`ifdef MIPS_MC_JLINK_EN
        k = k || (o == JAL);
`endif
        return k;
    endfunction

    function automatic outs_t v_fetch(bit rdy);
        outs_t v = '0;
        v.alusrcb = 2'b01; v.alucontrol = 3'b010; v.irwrite = rdy; v.pcen = rdy;
        return v;
    endfunction
    function automatic outs_t v_decode(logic [5:0] o);
        outs_t v = '0;
        v.alusrcb = 2'b11; v.alucontrol = 3'b010; v.illegal = !op_known(o);
        return v;
    endfunction
    function automatic outs_t v_memadr();
        outs_t v = '0;
        v.alusrca = 1'b1; v.alusrcb = 2'b10; v.signext = 1'b1; v.alucontrol = 3'b010;
        return v;
    endfunction
    function automatic outs_t v_memrd();
        outs_t v = '0;
        v.iord = 1'b1;
        return v;
    endfunction
    function automatic outs_t v_memwb();
        outs_t v = '0;
        v.regwrite = 1'b1; v.memtoreg = 1'b1;
        return v;
    endfunction
    function automatic outs_t v_memwr();
        outs_t v = '0;
        v.iord = 1'b1; v.memwrite = 1'b1;
        return v;
    endfunction
    function automatic outs_t v_exec(logic [5:0] f);
        outs_t v = '0;
        v.alusrca = 1'b1;
        case (f)
            6'b100000, 6'b100001: v.alucontrol = 3'b010;
            6'b100010, 6'b100011: v.alucontrol = 3'b110;
            6'b100100:            v.alucontrol = 3'b000;
            6'b100101:            v.alucontrol = 3'b001;
            6'b101010, 6'b101011: v.alucontrol = 3'b111;
            default:              v.illegal = 1'b1;
        endcase
        return v;
    endfunction
    function automatic outs_t v_aluwb();
        outs_t v = '0;
        v.regwrite = 1'b1; v.regdst = 1'b1;
        return v;
    endfunction
    function automatic outs_t v_branch(logic [5:0] o, bit z);
        outs_t v = '0;
        v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01;
        v.pcen = (o == BEQ) ? z : !z;
        return v;
    endfunction
    function automatic outs_t v_iexec(logic [5:0] o);
        outs_t v = '0;
        v.alusrca = 1'b1; v.alusrcb = 2'b10;
        v.alucontrol = (o == ORI) ? 3'b001 : 3'b010;
        v.signext = (o != ORI);
        v.shiftl16 = (o == LUI);
        return v;
    endfunction
    function automatic outs_t v_iwb();
        outs_t v = '0;
        v.regwrite = 1'b1;
        return v;
    endfunction
    function automatic outs_t v_jump(bit lnk);
        outs_t v = '0;
        v.pcsrc = 2'b10; v.pcen = 1'b1; v.regwrite = lnk; v.link = lnk;
        return v;
    endfunction
    function automatic outs_t v_jr();
        outs_t v = '0;
        v.pcsrc = 2'b11; v.pcen = 1'b1;
        return v;
    endfunction

    task automatic chk(string name, outs_t got, outs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(bit rst, bit rdy, bit z);
        @(negedge clk);
        reset = rst; mem_ready = rdy; zero = z; op = cur_op; funct = cur_funct;
        #1;
    endtask

    task automatic reset1();
        drive(1'b1, 1'b0, 1'b0);
        chk("reset_a", o_a, '0);
        chk("reset_b", o_b, '0);
    endtask

    task automatic push(outs_t v, bit r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    // Expand one instruction into its expected cycle list and mem_ready pattern
    task automatic build(logic [5:0] o, logic [5:0] f, bit z, int wf, int wd);
        outs_t ex;
        repeat (wf) push(v_fetch(1'b0), 1'b0);
        push(v_fetch(1'b1), 1'b1);
        push(v_decode(o), 1'($urandom_range(1)));
        if (!op_known(o)) return;
        if (o == LW) begin
            push(v_memadr(), 1'($urandom_range(1)));
            repeat (wd) push(v_memrd(), 1'b0);
            push(v_memrd(), 1'b1);
            push(v_memwb(), 1'($urandom_range(1)));
        end else if (o == SW) begin
            push(v_memadr(), 1'($urandom_range(1)));
            repeat (wd) push(v_memwr(), 1'b0);
            push(v_memwr(), 1'b1);
        end else if (o == RT) begin
`ifdef MIPS_MC_JLINK_EN
            if (f == 6'b001000) begin
                push(v_jr(), 1'($urandom_range(1)));
                return;
            end
`endif
            ex = v_exec(f);
            push(ex, 1'($urandom_range(1)));
            if (!ex.illegal) push(v_aluwb(), 1'($urandom_range(1)));
        end else if (o == BEQ || o == BNE) begin
            push(v_branch(o, z), 1'($urandom_range(1)));
        end else if (o == JMP) begin
            push(v_jump(1'b0), 1'($urandom_range(1)));
        end else if (o == JAL) begin
            push(v_jump(1'b1), 1'($urandom_range(1)));
        end else begin
            push(v_iexec(o), 1'($urandom_range(1)));
            push(v_iwb(), 1'($urandom_range(1)));
        end
    endtask

    function automatic vec_t mkv(logic [5:0] o, logic [5:0] f, bit z, outs_t nxt);
        vec_t t;
        t.op = o; t.funct = f; t.z = z; t.exp_dec = v_decode(o); t.exp_nxt = nxt;
        return t;
    endfunction

    initial begin
        logic [5:0] ops[15];
        logic [5:0] fns[10];
        outs_t tov;

        // Table: instruction -> decode-cycle and following-cycle outputs
        tbl.push_back(mkv(LW,  6'd0, 1'b0, v_memadr()));
        tbl.push_back(mkv(SW,  6'd0, 1'b0, v_memadr()));
        tbl.push_back(mkv(RT,  6'b100000, 1'b0, v_exec(6'b100000)));
        tbl.push_back(mkv(RT,  6'b100010, 1'b0, v_exec(6'b100010)));
        tbl.push_back(mkv(RT,  6'b100100, 1'b0, v_exec(6'b100100)));
        tbl.push_back(mkv(RT,  6'b100101, 1'b0, v_exec(6'b100101)));
        tbl.push_back(mkv(RT,  6'b101011, 1'b0, v_exec(6'b101011)));
        tbl.push_back(mkv(RT,  6'b000000, 1'b0, v_exec(6'b000000)));
        tbl.push_back(mkv(BEQ, 6'd0, 1'b1, v_branch(BEQ, 1'b1)));
        tbl.push_back(mkv(BEQ, 6'd0, 1'b0, v_branch(BEQ, 1'b0)));
        tbl.push_back(mkv(BNE, 6'd0, 1'b0, v_branch(BNE, 1'b0)));
        tbl.push_back(mkv(BNE, 6'd0, 1'b1, v_branch(BNE, 1'b1)));
        tbl.push_back(mkv(ADDI, 6'd0, 1'b0, v_iexec(ADDI)));
        tbl.push_back(mkv(ORI, 6'd0, 1'b0, v_iexec(ORI)));
        tbl.push_back(mkv(LUI, 6'd0, 1'b0, v_iexec(LUI)));
        tbl.push_back(mkv(JMP, 6'd0, 1'b0, v_jump(1'b0)));
        tbl.push_back(mkv(6'b111111, 6'd0, 1'b0, v_fetch(1'b1)));
`ifdef MIPS_MC_JLINK_EN
        tbl.push_back(mkv(JAL, 6'd0, 1'b0, v_jump(1'b1)));
        tbl.push_back(mkv(RT, 6'b001000, 1'b0, v_jr()));
`else
        tbl.push_back(mkv(JAL, 6'd0, 1'b0, v_fetch(1'b1)));
        tbl.push_back(mkv(RT, 6'b001000, 1'b0, v_exec(6'b001000)));
`endif

        // Reset held two cycles with mem_ready high, then first fetch
        drive(1'b1, 1'b1, 1'b0); chk("rst0_a", o_a, '0); chk("rst0_b", o_b, '0);
        drive(1'b1, 1'b1, 1'b0); chk("rst1_a", o_a, '0); chk("rst1_b", o_b, '0);
        drive(1'b0, 1'b1, 1'b0);
        chk("fetch1_a", o_a, v_fetch(1'b1)); chk("fetch1_b", o_b, v_fetch(1'b1));
        reset1();

        foreach (tbl[i]) begin
            cur_op = tbl[i].op; cur_funct = tbl[i].funct;
            drive(1'b0, 1'b1, tbl[i].z);
            chk($sformatf("tbl%0d_fetch", i), o_a, v_fetch(1'b1));
            drive(1'b0, 1'b1, tbl[i].z);
            chk($sformatf("tbl%0d_dec", i), o_a, tbl[i].exp_dec);
            chk($sformatf("tbl%0d_dec_b", i), o_b, tbl[i].exp_dec);
            drive(1'b0, 1'b1, tbl[i].z);
            chk($sformatf("tbl%0d_nxt", i), o_a, tbl[i].exp_nxt);
            chk($sformatf("tbl%0d_nxt_b", i), o_b, tbl[i].exp_nxt);
            reset1();
        end

        // Store waiting three cycles: unbounded copy holds strobe, bounded copy times out
        cur_op = SW; cur_funct = '0;
        drive(1'b0, 1'b1, 1'b0); chk("sw_fetch", o_a, v_fetch(1'b1));
        drive(1'b0, 1'b1, 1'b0); chk("sw_dec", o_a, v_decode(SW));
        drive(1'b0, 1'b1, 1'b0); chk("sw_adr", o_a, v_memadr()); chk("sw_adr_b", o_b, v_memadr());
        tov = v_memwr(); tov.memwrite = 1'b0; tov.bus_err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk($sformatf("sw_wait%0d", k), o_a, v_memwr());
            chk($sformatf("sw_wait%0d_b", k), o_b, (k < 2) ? v_memwr() : tov);
        end
        drive(1'b0, 1'b1, 1'b0);
        chk("sw_done", o_a, v_memwr()); chk("sw_to_refetch_b", o_b, v_fetch(1'b1));
        drive(1'b0, 1'b0, 1'b0); chk("sw_after", o_a, v_fetch(1'b0));
        reset1();

        // Fetch timeout on the bounded copy, then the counter restarts
        tov = v_fetch(1'b0); tov.bus_err = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk($sformatf("fwait%0d", k), o_a, v_fetch(1'b0));
            chk($sformatf("fwait%0d_b", k), o_b, (k == 2) ? tov : v_fetch(1'b0));
        end
        reset1();

        // Random instruction stream; waits <= 2 so both copies share the expectation
        ops = '{LW, SW, RT, RT, RT, BEQ, BNE, ADDI, ADDIU, ORI, LUI, JMP, JAL,
                6'b111111, 6'b010001};
        fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                6'b101010, 6'b101011, 6'b001000, 6'b000000};
        for (int n = 0; n < 250; n++) begin
            logic [5:0] o, f;
            bit z;
            o = ops[$urandom_range(14)];
            f = fns[$urandom_range(9)];
            z = 1'($urandom_range(1));
            exp_q.delete(); rdy_q.delete();
            build(o, f, z, int'($urandom_range(2)), int'($urandom_range(2)));
            cur_op = o; cur_funct = f;
            foreach (exp_q[k]) begin
                drive(1'b0, rdy_q[k], z);
                chk($sformatf("rnd%0d_op%b_c%0d", n, o, k), o_a, exp_q[k]);
                chk($sformatf("rnd%0d_op%b_c%0d_b", n, o, k), o_b, exp_q[k]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
